// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite bus codes, responder FSM encoding and byte-lane helpers.
// Pure definitions: no latency and no flow control of its own.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Little-endian lane enables for a naturally aligned access.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b1111;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << off;
      HSIZE_HALF: m = 4'b0011 << {off[1], 1'b0};
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~off[0];
      HSIZE_WORD: ok = (off == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_lite_slave_mem.sv
// Word register file: byte-enable write on the clock edge, combinational read, synchronous clear.
// Always ready; the caller sequences writes.
module ahb_lite_slave_mem
  import ahb_lite_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_lite_slave.sv
// AHB-Lite responder over a local word memory: data phase completes after WAIT_STATES
// HREADYOUT-low cycles (OKAY) or a fixed two-cycle ERROR; address phase accepted only with HREADY high.
module ahb_lite_slave
  import ahb_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          hreadyout_q;
  logic          hresp_q;
  logic          dp_valid;
  logic          dp_legal;
  logic          dp_write;
  logic [2:0]    dp_size;
  logic [1:0]    dp_off;
  logic [AW-1:0] dp_idx;

  logic [31:0] offset;
  logic        in_range;
  logic        legal;
  logic        sample;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        unused_ok;

  // Burst type and the SEQ/NONSEQ distinction do not change the response.
  assign unused_ok = ^{HBURST, HTRANS[0]};

  assign offset   = HADDR - BASE_ADDR;
  assign in_range = (HADDR >= BASE_ADDR) && (offset[31:AW+2] == '0);
  assign legal    = in_range && size_aligned(HSIZE, HADDR[1:0]);
  assign sample   = HSEL && HREADY && HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      dp_valid    <= 1'b0;
      dp_legal    <= 1'b0;
      dp_write    <= 1'b0;
      dp_size     <= HSIZE_BYTE;
      dp_off      <= '0;
      dp_idx      <= '0;
    end else begin
      if (sample) begin
        dp_valid <= 1'b1;
        dp_legal <= legal;
        dp_write <= HWRITE;
        dp_size  <= HSIZE;
        dp_off   <= HADDR[1:0];
        dp_idx   <= offset[AW+1:2];
      end else if (hreadyout_q) begin
        dp_valid <= 1'b0;
      end

      case (state)
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          // ST_IDLE and ST_ERR2 are both completing cycles that may accept a new transfer.
          if (sample && !legal) begin
            state       <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else if (sample && (WAIT_STATES > 0)) begin
            state       <= ST_WAIT;
            wait_cnt    <= 4'(WAIT_STATES - 1);
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_OKAY;
          end else begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign mem_we = dp_valid && dp_legal && dp_write && hreadyout_q;

  ahb_lite_slave_mem #(
    .DEPTH (MEM_DEPTH)
  ) u_mem (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .we      (mem_we),
    .idx     (dp_idx),
    .be      (lane_mask(dp_size, dp_off)),
    .wdata   (HWDATA),
    .rdata   (mem_rdata)
  );

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = (dp_valid && dp_legal && !dp_write) ? mem_rdata : 32'h0;

endmodule

// File: doc/ahb_lite_slave.md
Name: ahb_lite_slave

Overview:
AHB-Lite responder with a local word-addressed register memory, for use on the bus driven by the team's AHB-Lite master.
- Captures address-phase controls, then completes the data phase with programmable wait states.
- Performs byte/halfword/word reads and writes with little-endian byte lanes.
- Returns the two-cycle ERROR response for illegal accesses.
- One instance sits behind each HSELx line of the decoder.

Parameters:
BASE_ADDR, 32'h0000_0000, first byte address decoded by this slave (word aligned)
MEM_DEPTH, 256, number of 32-bit words; must be a power of 2, minimum 4
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15)

Ports:
HCLK  input  1  bus clock; all logic on the rising edge
HRESETn  input  1  reset, synchronous, active-low
HSEL  input  1  slave select from the address decoder
HADDR  input  32  transfer address
HTRANS  input  2  0=IDLE 1=BUSY 2=NONSEQ 3=SEQ
HWRITE  input  1  1=write, 0=read
HSIZE  input  3  0=byte 1=half 2=word; values 3 and above are illegal
HBURST  input  3  burst type; accepted, no effect on the response
HWDATA  input  32  write data, valid during the data phase
HREADY  input  1  bus-wide ready (muxed HREADYOUT of all slaves)
HREADYOUT  output  1  this slave's ready
HRESP  output  1  0=OKAY 1=ERROR
HRDATA  output  32  read data

Behaviour:
- Reset (HRESETn low at a rising edge), values after that edge:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM in ST_IDLE, wait counter 0, all memory words 0.
  - Any pending data phase is aborted; no memory write occurs.
- Address-phase sample: at a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ or SEQ).
  - Latch HADDR, HWRITE and HSIZE into data-phase registers.
  - Set dp_valid=1.
- No sample otherwise. HTRANS of IDLE or BUSY, HSEL=0, or HREADY=0 gives dp_valid=0 and a zero-wait OKAY response.
- Legality check, made at sample time:
  - Illegal if HADDR is outside BASE_ADDR..BASE_ADDR+4*MEM_DEPTH-1.
  - Illegal if HSIZE is 3 or above.
  - Illegal if HSIZE=1 and HADDR[0]=1, or HSIZE=2 and HADDR[1:0]!=0.
- FSM states and transitions:
  - ST_IDLE: HREADYOUT=1, HRESP=0.
    - Legal sample with WAIT_STATES>0 -> ST_WAIT, counter loaded with WAIT_STATES-1.
    - Legal sample with WAIT_STATES=0 -> stays in ST_IDLE; the data phase completes on the next edge.
    - Illegal sample -> ST_ERR1.
  - ST_WAIT: HREADYOUT=0, HRESP=0.
    - Counter decrements each cycle.
    - At 0 -> ST_IDLE, whose first cycle is the completing cycle (HREADYOUT=1).
  - ST_ERR1: HREADYOUT=0, HRESP=1 -> ST_ERR2 unconditionally.
  - ST_ERR2: HREADYOUT=1, HRESP=1.
    - Acts as the completing cycle; a new sample here is legal.
    - Next state follows the ST_IDLE rules.
  - ERROR responses never incur wait states.
- Write completion:
  - Occurs at the edge where dp_valid=1, the access is legal and HREADYOUT=1.
  - Memory word index = (latched addr - BASE_ADDR)>>2.
  - Byte lanes written by size and offset:
    - Byte: lane = addr[1:0].
    - Half: lanes addr[1]*2 and addr[1]*2+1.
    - Word: all four lanes.
  - Lanes not enabled are preserved.
  - Illegal writes never modify memory.
- Read data:
  - HRDATA is combinational: the full memory word at the latched address while a legal read data phase is active (including wait cycles).
  - HRDATA is 0 otherwise and during ERR1/ERR2.
  - The master extracts the lane.
  - Read-after-write to the same word in back-to-back transfers returns the new data, because the write lands at the edge that starts the read data phase.
- Data-phase clearing: dp_valid clears at completion unless a new sample occurs on the same edge; pipelined back-to-back transfers are supported.
- Simultaneous reset and sample: reset wins.
- HBURST does not affect the response: BUSY inside a burst gets a zero-wait OKAY, and SEQ is treated exactly as NONSEQ.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ).
  - HSIZE codes (BYTE/HALF/WORD).
  - HBURST codes (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16 = 0..7).
  - HRESP codes (OKAY=0, ERROR=1).
  - FSM state encoding.
- Sub-module ahb_lite_slave_mem:
  - Register array of MEM_DEPTH words with synchronous clear.
  - 4-bit byte-enable write, combinational read.

Test Plan:
1. Word write then read, WAIT_STATES=0: NONSEQ write 0x10 data 0xDEADBEEF, then NONSEQ read 0x10 -> HREADYOUT stays 1, HRESP=0, HRDATA=0xDEADBEEF in the read data phase.
2. Byte and half lanes: write word 0x20=0x00000000, byte 0x22=0xAB (HWDATA 0x00AB0000), half 0x20=0x1234 -> read 0x20 returns 0x00AB1234.
3. Wait states, WAIT_STATES=2: single read -> HREADYOUT 0,0,1 across the data phase; HRDATA valid on all three cycles; next address phase sampled only on the third.
4. Errors: read 0x11 with HSIZE=2, and access to BASE_ADDR+4*MEM_DEPTH -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); a following legal read returns OKAY; memory unchanged.
5. INCR4 write burst 0x40..0x4C with one BUSY after beat 2 -> BUSY cycle gets a zero-wait OKAY; all four words written in order; readback matches.
6. Reset mid-operation: assert HRESETn=0 during ST_WAIT of a write to 0x30 -> after that edge HREADYOUT=1, HRESP=0, HRDATA=0; word 0x30 reads back 0.
